// File: rtl/tv_b_gone_pkg.sv
// Shared types for the remote-control button path: decoder FSM states and code regions.
// Also provides the window-counter width helper used by the press decoder.
package tv_b_gone_pkg;

  typedef enum logic {
    IDLE        = 1'b0,
    WAIT_SECOND = 1'b1
  } btn_state_t;

  typedef enum logic {
    REGION_NA = 1'b0,
    REGION_EU = 1'b1
  } region_t;

  // One-cycle classification pulses, registered together.
  typedef struct packed {
    logic single;
    logic dbl;
    logic start;
    logic stop;
  } press_evt_t;

  // A window of one cycle still needs a one-bit counter.
  function automatic int cnt_width(input longint w);
    if (w < 2)
      return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector: rise_out is combinational from level_in and one registered copy.
// A level already high when reset releases is not reported as a rise.
module btn_edge_detect (
  input  logic clock_in,
  input  logic reset_in,
  input  logic level_in,
  output logic rise_out
);

  logic level_d;
  logic armed;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      level_d <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_d <= level_in;
      armed   <= 1'b1;
    end
  end

  // armed masks the first post-reset cycle, while level_d still holds the reset value.
  assign rise_out = armed & level_in & ~level_d;

endmodule

// File: rtl/btn_press_decoder.sv
// Classifies debounced presses as single or double within a W-cycle window; outputs registered,
// single after W cycles, double one cycle after the second rise; no backpressure, seq_busy_in picks start/stop.
module btn_press_decoder
  import tv_b_gone_pkg::*;
#(
  parameter int CLK_MHZ          = 8,
  parameter int DOUBLE_WINDOW_MS = 400
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic press_in,
  input  logic seq_busy_in,
  output logic single_out,
  output logic double_out,
  output logic start_out,
  output logic stop_out,
  output logic region_out
);

  localparam longint W  = longint'(CLK_MHZ) * longint'(DOUBLE_WINDOW_MS) * 64'sd1000;
  localparam int     CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

  btn_state_t    state;
  logic [CW-1:0] cnt;
  press_evt_t    evt;
  region_t       region;
  logic          rise;

  btn_edge_detect u_edge (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .level_in (press_in),
    .rise_out (rise)
  );

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state  <= IDLE;
      cnt    <= CNT_LOAD;
      evt    <= '0;
      region <= REGION_NA;
    end else begin
      evt <= '0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= WAIT_SECOND;
            cnt   <= CNT_LOAD;
          end
        end
        WAIT_SECOND: begin
          // A rise on the expiry cycle still counts as the second press.
          if (rise) begin
            evt.dbl <= 1'b1;
            region  <= (region == REGION_NA) ? REGION_EU : REGION_NA;
            state   <= IDLE;
          end else if (cnt == '0) begin
            evt.single <= 1'b1;
            evt.start  <= ~seq_busy_in;
            evt.stop   <= seq_busy_in;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign single_out = evt.single;
  assign double_out = evt.dbl;
  assign start_out  = evt.start;
  assign stop_out   = evt.stop;
  assign region_out = region;

endmodule

// File: tb/tb_btn_press_decoder.sv
// Randomized and directed bench for btn_press_decoder with a time-based reference model
// and a queue scoreboard drained by an independent output monitor.
module tb_btn_press_decoder;

  localparam int W = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic press = 1'b0;
  logic busy = 1'b0;
  logic single_o, double_o, start_o, stop_o, region_o;

  btn_press_decoder #(.CLK_MHZ(1), .DOUBLE_WINDOW_MS(1)) dut (
    .clock_in    (clk),
    .reset_in    (rst),
    .press_in    (press),
    .seq_busy_in (busy),
    .single_out  (single_o),
    .double_out  (double_o),
    .start_out   (start_o),
    .stop_out    (stop_o),
    .region_out  (region_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int   cyc;
    logic s;
    logic d;
    logic st;
    logic sp;
    logic rg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a press is remembered by the cycle its rise was seen.
  bit   pend = 1'b0;
  int   pend_c0 = 0;
  bit   skip = 1'b1;
  logic p_prev = 1'b0;
  logic b_prev = 1'b0;
  logic m_region = 1'b0;

  task automatic push_exp(input int c, input logic s, input logic d,
                          input logic st, input logic sp, input logic rg);
    exp_t e;
    e.cyc = c; e.s = s; e.d = d; e.st = st; e.sp = sp; e.rg = rg;
    q.push_back(e);
  endtask

  task automatic step(input logic p, input logic b, input logic r);
    @(posedge clk);
    #1;
    press = p;
    busy  = b;
    rst   = r;
    // Window expired on the previous edge: single, with busy as seen on that edge.
    if (pend && cyc == pend_c0 + W + 1) begin
      push_exp(cyc, 1'b1, 1'b0, ~b_prev, b_prev, m_region);
      pend = 1'b0;
    end
    if (r) begin
      pend     = 1'b0;
      skip     = 1'b1;
      m_region = 1'b0;
    end else if (skip) begin
      skip = 1'b0;
    end else if (p && !p_prev) begin
      if (pend) begin
        m_region = ~m_region;
        push_exp(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, m_region);
        pend = 1'b0;
      end else begin
        pend    = 1'b1;
        pend_c0 = cyc;
      end
    end
    p_prev = p;
    b_prev = b;
  endtask

  task automatic run(input logic p, input logic b, input logic r, input int n);
    for (int i = 0; i < n; i++) step(p, b, r);
  endtask

  bit       mon_en = 1'b0;
  logic     exp_region = 1'b0;
  logic [3:0] got;
  int       region_prints = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_event cyc=%0d expected at %0d sdss=%b%b%b%b got nothing",
                   cyc, q[0].cyc, q[0].s, q[0].d, q[0].st, q[0].sp);
          void'(q.pop_front());
        end
        got = {single_o, double_o, start_o, stop_o};
        if (got !== 4'b0000) begin
          exp_t e;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got sdss=%b required none", cyc, got);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || got !== {e.s, e.d, e.st, e.sp}) begin
              errors++;
              $display("FAIL event cyc=%0d got sdss=%b required sdss=%b%b%b%b at cyc=%0d",
                       cyc, got, e.s, e.d, e.st, e.sp, e.cyc);
            end
            if (e.d) exp_region = e.rg;
          end
        end
        checks++;
        if (region_o !== exp_region) begin
          errors++;
          if (region_prints < 20) begin
            region_prints++;
            $display("FAIL region cyc=%0d got %b required %b", cyc, region_o, exp_region);
          end
        end
        if (rst) exp_region = 1'b0;
      end
    end
  end

  initial begin
    logic b;
    int   hold, gap;

    run(1'b0, 1'b0, 1'b1, 4);
    @(negedge clk);
    checks++;
    if ({single_o, double_o, start_o, stop_o, region_o} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state got sdssr=%b%b%b%b%b required 00000",
               single_o, double_o, start_o, stop_o, region_o);
    end
    mon_en = 1'b1;

    // Single press, idle sequencer, then busy sequencer.
    run(1'b1, 1'b0, 1'b0, 50);
    run(1'b0, 1'b0, 1'b0, 1100);
    run(1'b1, 1'b1, 1'b0, 50);
    run(1'b0, 1'b1, 1'b0, 1100);

    // Double press at 0 and 300, twice so region returns to NA.
    for (int k = 0; k < 2; k++) begin
      run(1'b1, 1'b0, 1'b0, 50);
      run(1'b0, 1'b0, 1'b0, 250);
      run(1'b1, 1'b0, 1'b0, 20);
      run(1'b0, 1'b0, 1'b0, 1100);
    end

    // Second rise exactly on expiry, then one cycle too late.
    run(1'b1, 1'b0, 1'b0, 1);
    run(1'b0, 1'b0, 1'b0, W - 1);
    run(1'b1, 1'b0, 1'b0, 1);
    run(1'b0, 1'b0, 1'b0, 1100);
    run(1'b1, 1'b1, 1'b0, 1);
    run(1'b0, 1'b1, 1'b0, W);
    run(1'b1, 1'b0, 1'b0, 1);
    run(1'b0, 1'b0, 1'b0, 1100);

    // Reset mid-window, then a normal single press.
    run(1'b1, 1'b0, 1'b0, 1);
    run(1'b0, 1'b0, 1'b0, 499);
    run(1'b0, 1'b0, 1'b1, 1);
    run(1'b0, 1'b0, 1'b0, 1100);
    run(1'b1, 1'b0, 1'b0, 50);
    run(1'b0, 1'b0, 1'b0, 1100);

    // Press held through reset release must not count.
    run(1'b1, 1'b0, 1'b1, 3);
    run(1'b1, 1'b0, 1'b0, 100);
    run(1'b0, 1'b0, 1'b0, 1100);

    // Long held level counts once.
    run(1'b1, 1'b0, 1'b0, 5000);
    run(1'b0, 1'b0, 1'b0, 1100);

    for (int k = 0; k < 25; k++) begin
      b    = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 300);
      gap  = $urandom_range(1, 1200);
      if ($urandom_range(0, 9) == 0)
        run(1'($urandom_range(0, 1)), b, 1'b1, $urandom_range(1, 3));
      run(1'b1, b, 1'b0, hold);
      run(1'b0, 1'($urandom_range(0, 1)), 1'b0, gap);
    end

    run(1'b0, 1'b0, 1'b0, W + 20);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d events outstanding required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_press_decoder.md
BTN_PRESS_DECODER -- requirements
Module: btn_press_decoder

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 8: clock frequency in MHz.
REQ-002 SHALL have parameter DOUBLE_WINDOW_MS, default 400: double-press window in ms; W = CLK_MHZ*DOUBLE_WINDOW_MS*1000 cycles.
REQ-003 SHALL have port clock_in  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_in  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port press_in  input  1  debounced press from the upstream debouncer; high for up to one debounce period per press.
REQ-006 SHALL have port seq_busy_in  input  1  IR sequencer is transmitting.
REQ-007 SHALL have port single_out  output  1  one-cycle pulse: single press classified.
REQ-008 SHALL have port double_out  output  1  one-cycle pulse: double press classified.
REQ-009 SHALL have port start_out  output  1  one-cycle request to the sequencer to start transmission.
REQ-010 SHALL have port stop_out  output  1  one-cycle request to the sequencer to abort transmission.
REQ-011 SHALL have port region_out  output  1  code region: 0 = NA, 1 = EU.

Function
REQ-012 SHALL register press_in into press_d each cycle; rise = press_in & !press_d; only rises count as presses, so a high level of any length counts once.
REQ-013 SHALL implement FSM states IDLE and WAIT_SECOND.
REQ-014 In IDLE, a rise SHALL move to WAIT_SECOND and load the window counter with W-1.
REQ-015 In WAIT_SECOND with counter != 0 and no rise, the counter SHALL decrement by 1.
REQ-016 In WAIT_SECOND, a rise SHALL classify a double press: double_out=1 next cycle, region_out toggles, state returns to IDLE, and no start/stop is issued.
REQ-017 In WAIT_SECOND, counter == 0 with no rise SHALL classify a single press: single_out=1 next cycle, state returns to IDLE.
REQ-018 On a single press, start_out=1 if seq_busy_in=0, else stop_out=1; seq_busy_in is sampled in the same cycle as classification.
REQ-019 If a rise and counter == 0 coincide in WAIT_SECOND, the double press SHALL win.
REQ-020 single_out SHALL assert exactly W cycles after the edge that sampled the first rise; double_out SHALL assert the cycle after the edge that sampled the second rise.
REQ-021 All outputs SHALL be registered; each of single_out, double_out, start_out and stop_out SHALL be high for exactly one cycle per event.
REQ-022 start_out and stop_out SHALL never be high in the same cycle, and neither SHALL be high in a cycle where double_out is high.
REQ-023 A rise in the cycle where the state returns to IDLE SHALL be evaluated from IDLE on the next edge and is therefore not lost, because press_d holds the pre-rise value.
REQ-024 The counter width SHALL be $clog2(W); the counter SHALL never wrap below 0.

Reset
REQ-025 While reset_in=1: state=IDLE, counter=W-1, press_d=0, single_out=0, double_out=0, start_out=0, stop_out=0, region_out=0.
REQ-026 Reset asserted mid-window SHALL discard the pending press with no output pulse; a press_in already high when reset releases SHALL NOT count as a rise.

Structure
REQ-027 Shared package tv_b_gone_pkg SHALL hold the FSM state enum (IDLE, WAIT_SECOND) and the region enum (REGION_NA=0, REGION_EU=1).
REQ-028 The rise detector SHALL be the sub-module btn_edge_detect (clock_in, reset_in, level_in, rise_out), reusable elsewhere; the window counter stays inline.

Verification
REQ-029 Bench SHALL use CLK_MHZ=1 and DOUBLE_WINDOW_MS=1, giving W=1000.
REQ-030 Single press while idle: press_in high 50 cycles, seq_busy_in=0 -> single_out and start_out high for 1 cycle, 1000 cycles after the rise; stop_out, double_out and region_out stay 0.
REQ-031 Single press while busy: seq_busy_in=1, one press -> single_out and stop_out pulse once at +1000 cycles; start_out stays 0.
REQ-032 Double press: rises at cycle 0 and cycle 300 -> double_out pulses at cycle 301, region_out goes 0->1, no single/start/stop; a repeat double press returns region_out to 0.
REQ-033 Coincident boundary: second rise lands on the counter==0 cycle -> double_out only, no single_out.
REQ-034 Reset mid-window: reset_in pulsed at cycle 500 after a rise -> no output pulses at all; region_out=0; a later single press behaves as in REQ-030.
REQ-035 Held level: press_in high for 5000 cycles -> exactly one single_out pulse.
